collision_detection: RTL and testbench
======================================

// Module: collision_detection
// PURPOSE
//  Placement checker for the car-grid game. Holds the footprint of up to NUM_CARS cars.
//  Each cycle it tests one requested placement (carIndex, carX, carY, carOrient) against
//  the board bounds and every other stored car, and flags a collision.
//  Accepted placements update that car's stored position. Sits between game control and renderer.
// PARAMETERS
//  COORD_W   10  width of carX/carY (grid cells)
//  GRID_W    32  board width in cells; legal x = 0..GRID_W-1
//  GRID_H    32  board height in cells; legal y = 0..GRID_H-1
//  CAR_LEN   2   car length in cells along its orientation
//  NUM_CARS  8   table entries (power of 2)
//  IDX_W     3   width of carIndex = log2(NUM_CARS)
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        synchronous active-high reset
//  carX       in   COORD_W  requested anchor column (leftmost/topmost cell)
//  carY       in   COORD_W  requested anchor row
//  carOrient  in   1        0 = horizontal, 1 = vertical
//  carIndex   in   IDX_W    car being placed
//  collision  out  1        registered; 1 = requested placement rejected
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset (rst=1 at a rising edge):
//    - collision <= 0.
//    - All table entries marked invalid (x, y, orient cleared to 0).
//    - Reset dominates all other inputs in that cycle.
//  - Footprint of a placement:
//    - w = CAR_LEN, h = 1 if orient = 0; w = 1, h = CAR_LEN if orient = 1.
//    - Covers cells x..x+w-1, y..y+h-1.
//  - Every non-reset cycle, inputs are sampled and the request is evaluated combinationally:
//    - oob = (carX + w > GRID_W) | (carY + h > GRID_H).
//      Sums are computed COORD_W+1 bits wide, with no wrap.
//    - hit[i] = valid[i] & (i != carIndex) & (ax < bx+bw) & (bx < ax+aw) & (ay < by+bh) & (by < ay+ah).
//      a = request, b = entry i; all sums COORD_W+1 bits wide.
//    - col = oob | (|hit).
//  - Registered outputs and table update:
//    - collision <= col. Latency is 1 cycle: the flag for inputs sampled at edge N is visible after edge N.
//    - If col = 0: entry[carIndex] <= {carX, carY, carOrient} and valid[carIndex] <= 1.
//    - If col = 1: the table is unchanged; the car keeps its last accepted position.
//  - Self-test excluded: re-placing a car over its own old footprint is never a collision.
//  - Holding the same inputs on consecutive cycles gives a stable collision value and an idempotent table.
//  - Touching edge-to-edge is not a collision, e.g. cells x = 4..5 vs x = 6..7.
//  - Boundary: a horizontal car at x = GRID_W-CAR_LEN is legal; at x = GRID_W-CAR_LEN+1 it is oob.
//  - No handshake: a request is presented every cycle.
// TESTING
//  1. Reset, hold inputs 0,0,0,idx0 -> collision=0 one cycle after reset release; entry0 valid at (0,0) horizontal.
//  2. idx0 to (10,10) orient1, then idx1 to (10,20) orient0 -> collision stays 0 throughout; both entries valid.
//  3. idx1 to (10,11) orient0 while car0 is vertical at (10,10) -> collision=1 next cycle; entry1 stays (10,20).
//  4. idx2 horizontal at (30,5) -> collision=0; idx2 at (31,5) -> collision=1 (oob); vertical at (5,31) -> 1.
//  5. idx0 moved from (10,10) vertical to (10,11) vertical -> collision=0 (self excluded); idx3 at (8,12) horizontal touching (10,12) -> 0.
//  6. Assert rst mid-sequence with a colliding request -> collision=0 next cycle; a previously blocked placement is then accepted.

Source files
------------

// File: rtl/collision_detection_if.sv
// Placement request bus between game control and the collision checker.
// Game control drives a request every cycle and reads back the registered flag.
interface collision_detection_if #(
    parameter int COORD_W = 10,
    parameter int IDX_W   = 3
);
    logic [COORD_W-1:0] carX;
    logic [COORD_W-1:0] carY;
    logic               carOrient;
    logic [IDX_W-1:0]   carIndex;
    logic               collision;

    modport master (
        output carX,
        output carY,
        output carOrient,
        output carIndex,
        input  collision
    );

    modport slave (
        input  carX,
        input  carY,
        input  carOrient,
        input  carIndex,
        output collision
    );
endinterface

// File: rtl/collision_detection.sv
// Car-grid placement checker: tests one requested placement per cycle
// against board bounds and every other stored car, and stores accepted ones.
module collision_detection #(
    parameter int COORD_W  = 10,
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 32,
    parameter int CAR_LEN  = 2,
    parameter int NUM_CARS = 8,
    parameter int IDX_W    = 3
) (
    input logic                 clk,
    input logic                 rst,
    collision_detection_if.slave bus
);
    typedef logic [COORD_W:0] sum_t;

    localparam sum_t GW  = sum_t'(GRID_W);
    localparam sum_t GH  = sum_t'(GRID_H);
    localparam sum_t LEN = sum_t'(CAR_LEN);
    localparam sum_t ONE = sum_t'(1);

    function automatic sum_t w_of(input logic orient);
        return orient ? ONE : LEN;
    endfunction

    function automatic sum_t h_of(input logic orient);
        return orient ? LEN : ONE;
    endfunction

    logic [COORD_W-1:0] x_q [NUM_CARS];
    logic [COORD_W-1:0] x_d [NUM_CARS];
    logic [COORD_W-1:0] y_q [NUM_CARS];
    logic [COORD_W-1:0] y_d [NUM_CARS];
    logic [NUM_CARS-1:0] orient_q;
    logic [NUM_CARS-1:0] orient_d;
    logic [NUM_CARS-1:0] valid_q;
    logic [NUM_CARS-1:0] valid_d;
    logic                collision_q;
    logic                collision_d;

    sum_t                a_x;
    sum_t                a_y;
    sum_t                a_w;
    sum_t                a_h;
    logic                oob;
    logic [NUM_CARS-1:0] hit;
    logic                col;

    // Evaluate the request against bounds and every other valid entry.
    always_comb begin
        a_x = {1'b0, bus.carX};
        a_y = {1'b0, bus.carY};
        a_w = w_of(bus.carOrient);
        a_h = h_of(bus.carOrient);
        oob = (a_x + a_w > GW) | (a_y + a_h > GH);
        hit = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            hit[i] = valid_q[i]
                   & (IDX_W'(i) != bus.carIndex)
                   & (a_x < {1'b0, x_q[i]} + w_of(orient_q[i]))
                   & ({1'b0, x_q[i]} < a_x + a_w)
                   & (a_y < {1'b0, y_q[i]} + h_of(orient_q[i]))
                   & ({1'b0, y_q[i]} < a_y + a_h);
        end
        col = oob | (|hit);
    end

    // Accepted placements overwrite the requesting car's entry.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        orient_d    = orient_q;
        valid_d     = valid_q;
        collision_d = col;
        if (!col) begin
            x_d[bus.carIndex]      = bus.carX;
            y_d[bus.carIndex]      = bus.carY;
            orient_d[bus.carIndex] = bus.carOrient;
            valid_d[bus.carIndex]  = 1'b1;
        end
    end

    // Table and flag registers; reset empties the table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            orient_q    <= '0;
            valid_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            orient_q    <= orient_d;
            valid_q     <= valid_d;
            collision_q <= collision_d;
        end
    end

    assign bus.collision = collision_q;
endmodule

// File: tb/tb_collision_detection.sv
// Self-checking bench for collision_detection: directed scenarios plus
// randomized placements checked against a cell-occupancy reference model.
module tb_collision_detection;
    localparam int GRID_W  = 32;
    localparam int GRID_H  = 32;
    localparam int CAR_LEN = 2;
    localparam int NCARS   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    collision_detection_if #(.COORD_W(10), .IDX_W(3)) bus ();

    collision_detection #(
        .COORD_W(10), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .CAR_LEN(CAR_LEN), .NUM_CARS(NCARS), .IDX_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference board: where each car sits, if anywhere.
    int mx [NCARS];
    int my [NCARS];
    bit mo [NCARS];
    bit mv [NCARS];

    // Does cell (cx,cy) belong to stored car j?
    function automatic bit occupies(int j, int cx, int cy);
        for (int k = 0; k < CAR_LEN; k++) begin
            int px = mo[j] ? mx[j] : mx[j] + k;
            int py = mo[j] ? my[j] + k : my[j];
            if (px == cx && py == cy) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Walk every cell of the requested car; reject off-board or occupied cells.
    function automatic bit model_col(int x, int y, bit o, int idx);
        for (int k = 0; k < CAR_LEN; k++) begin
            int cx = o ? x : x + k;
            int cy = o ? y + k : y;
            if (cx >= GRID_W || cy >= GRID_H) return 1'b1;
            for (int j = 0; j < NCARS; j++)
                if (mv[j] && j != idx && occupies(j, cx, cy)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive one request, clock it in, advance the model; exp is the model's flag.
    task automatic apply(input bit r, input int x, input int y, input bit o,
                         input int idx, output bit exp);
        @(negedge clk);
        rst           = r;
        bus.carX      = 10'(x);
        bus.carY      = 10'(y);
        bus.carOrient = o;
        bus.carIndex  = 3'(idx);
        exp = r ? 1'b0 : model_col(x, y, o, idx);
        @(posedge clk);
        if (r) begin
            for (int j = 0; j < NCARS; j++) mv[j] = 1'b0;
        end else if (!exp) begin
            mx[idx] = x; my[idx] = y; mo[idx] = o; mv[idx] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        bit e;
        apply(1, 0, 0, 0, 0, e);
        apply(1, 0, 0, 0, 0, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL reset_flag got=%b want=0", bus.collision);
        else passed++;
        apply(0, 0, 0, 0, 0, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL first_place got=%b want=0", bus.collision);
        else passed++;
        apply(0, 1, 0, 0, 1, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL entry0_stored got=%b want=1", bus.collision);
        else passed++;
        apply(0, 0, 1, 0, 1, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL below_car0 got=%b want=0", bus.collision);
        else passed++;
    endtask

    task automatic test_placement();
        bit e;
        apply(0, 10, 10, 1, 0, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL move_car0 got=%b want=0", bus.collision);
        else passed++;
        apply(0, 10, 20, 0, 1, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL move_car1 got=%b want=0", bus.collision);
        else passed++;
        apply(0, 11, 20, 0, 2, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL hit_car1 got=%b want=1", bus.collision);
        else passed++;
        apply(0, 9, 11, 0, 2, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL hit_car0 got=%b want=1", bus.collision);
        else passed++;
    endtask

    task automatic test_overlap();
        bit e;
        apply(0, 10, 11, 0, 1, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL overlap got=%b want=1", bus.collision);
        else passed++;
        apply(0, 10, 20, 1, 2, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL car1_kept got=%b want=1", bus.collision);
        else passed++;
        apply(0, 12, 11, 0, 2, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL free_spot got=%b want=0", bus.collision);
        else passed++;
    endtask

    task automatic test_bounds();
        bit e;
        apply(0, 30, 5, 0, 2, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL x_edge got=%b want=0", bus.collision);
        else passed++;
        apply(0, 31, 5, 0, 2, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL x_oob got=%b want=1", bus.collision);
        else passed++;
        apply(0, 5, 31, 1, 2, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL y_oob got=%b want=1", bus.collision);
        else passed++;
        apply(0, 5, 30, 1, 2, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL y_edge got=%b want=0", bus.collision);
        else passed++;
        apply(0, 1023, 0, 0, 7, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL x_max got=%b want=1", bus.collision);
        else passed++;
    endtask

    task automatic test_self_touch();
        bit e;
        apply(0, 10, 11, 1, 0, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL self_excl got=%b want=0", bus.collision);
        else passed++;
        apply(0, 8, 12, 0, 3, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL touch_h got=%b want=0", bus.collision);
        else passed++;
        apply(0, 9, 12, 0, 3, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL overlap_h got=%b want=1", bus.collision);
        else passed++;
        apply(0, 10, 13, 1, 4, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL touch_v got=%b want=0", bus.collision);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit e;
        for (int n = 0; n < 2; n++) begin
            apply(0, 20, 20, 0, 5, e);
            total++;
            if (bus.collision !== 1'b0)
                $display("FAIL hold_ok%0d got=%b want=0", n, bus.collision);
            else passed++;
        end
        for (int n = 0; n < 2; n++) begin
            apply(0, 21, 19, 1, 6, e);
            total++;
            if (bus.collision !== 1'b1)
                $display("FAIL hold_hit%0d got=%b want=1", n, bus.collision);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        bit e;
        apply(1, 9, 12, 0, 3, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL rst_dom got=%b want=0", bus.collision);
        else passed++;
        apply(0, 9, 12, 0, 3, e);
        total++;
        if (bus.collision !== 1'b0)
            $display("FAIL post_rst got=%b want=0", bus.collision);
        else passed++;
        apply(0, 10, 12, 1, 0, e);
        total++;
        if (bus.collision !== 1'b1)
            $display("FAIL new_entry got=%b want=1", bus.collision);
        else passed++;
    endtask

    task automatic test_random();
        bit e;
        for (int n = 0; n < 400; n++) begin
            bit r   = ($urandom_range(0, 39) == 0);
            int x   = $urandom_range(0, 33);
            int y   = $urandom_range(0, 33);
            bit o   = 1'($urandom_range(0, 1));
            int idx = $urandom_range(0, NCARS - 1);
            apply(r, x, y, o, idx, e);
            total++;
            if (bus.collision !== e)
                $display("FAIL rand%0d r=%0d idx=%0d (%0d,%0d,%0d) got=%b want=%b",
                         n, r, idx, x, y, o, bus.collision, e);
            else passed++;
        end
    endtask

    initial begin
        for (int j = 0; j < NCARS; j++) begin
            mx[j] = 0; my[j] = 0; mo[j] = 0; mv[j] = 0;
        end
        bus.carX      = '0;
        bus.carY      = '0;
        bus.carOrient = 1'b0;
        bus.carIndex  = '0;
        test_reset();
        test_placement();
        test_overlap();
        test_bounds();
        test_self_touch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
